// File: rtl/b06_pkg.sv
// Shared encodings for the b06 responder: compare selects, handler codes,
// config register addresses and the event FSM state type.
package b06_pkg;

    typedef enum logic [1:0] {
        CC_NONE = 2'b00,
        CC_A    = 2'b01,
        CC_B    = 2'b10,
        CC_C    = 2'b11
    } cc_sel_t;

    typedef enum logic [1:0] {
        USC_00 = 2'b00,
        USC_01 = 2'b01,
        USC_10 = 2'b10,
        USC_11 = 2'b11
    } uscite_t;

    localparam logic [1:0] CFG_REF_A = 2'd0;
    localparam logic [1:0] CFG_REF_B = 2'd1;
    localparam logic [1:0] CFG_REF_C = 2'd2;
    localparam logic [1:0] CFG_LIMIT = 2'd3;

    typedef enum logic {
        EV_IDLE = 1'b0,
        EV_HOLD = 1'b1
    } ev_state_t;

endpackage

// File: rtl/b06_resp_cnt.sv
// Enable-gated wrap counter with programmable limit and a one-cycle
// terminal pulse (cont_eql) for the b06 handler.
module b06_resp_cnt
    import b06_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable_count,
    input  logic             limit_we,
    input  logic [CNT_W-1:0] limit_wdata,
    output logic             cont_eql
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] limit;
    logic             at_limit;

    assign at_limit = (count == limit);

    // A limit write restarts the count and overrides counting that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            limit    <= '0;
            cont_eql <= 1'b0;
        end else begin
            if (limit_we) begin
                limit <= limit_wdata;
                count <= '0;
            end else if (enable_count) begin
                count <= at_limit ? '0 : count + CNT_W'(1);
            end
            cont_eql <= enable_count && at_limit;
        end
    end

endmodule

// File: rtl/b06_resp.sv
// b06 responder: reference compare (eql), counter (cont_eql) and ackout event
// handshake. Define B06_RESP_EQL_FILT_EN for the 2-cycle eql match filter.
module b06_resp
    import b06_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        cc_mux,
    input  logic [1:0]        uscite,
    input  logic              enable_count,
    input  logic              ackout,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              ev_ready,
    output logic              eql,
    output logic              cont_eql,
    output logic              ev_valid,
    output logic [1:0]        ev_code,
    output logic              ev_ovf
);

    logic [DATA_W-1:0] ref_a;
    logic [DATA_W-1:0] ref_b;
    logic [DATA_W-1:0] ref_c;
    logic [DATA_W-1:0] ref_sel;
    logic              raw_match;

    always_ff @(posedge clock) begin
        if (reset) begin
            ref_a <= '0;
            ref_b <= '0;
            ref_c <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_REF_A: ref_a <= cfg_wdata;
                CFG_REF_B: ref_b <= cfg_wdata;
                CFG_REF_C: ref_c <= cfg_wdata;
                default:   ;
            endcase
        end
    end

    always_comb begin
        ref_sel = '0;
        case (cc_mux)
            CC_A:    ref_sel = ref_a;
            CC_B:    ref_sel = ref_b;
            CC_C:    ref_sel = ref_c;
            default: ref_sel = '0;
        endcase
        raw_match = (cc_mux != CC_NONE) && (data_in == ref_sel);
    end

`ifdef B06_RESP_EQL_FILT_EN
    logic       match_q;
    logic [1:0] cc_q;

    // Match must hold on two consecutive samples with the same select.
    always_ff @(posedge clock) begin
        if (reset) begin
            match_q <= 1'b0;
            cc_q    <= CC_NONE;
            eql     <= 1'b0;
        end else begin
            match_q <= raw_match;
            cc_q    <= cc_mux;
            eql     <= raw_match && match_q && (cc_mux == cc_q);
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            eql <= 1'b0;
        end else begin
            eql <= raw_match;
        end
    end
`endif

    b06_resp_cnt #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clock        (clock),
        .reset        (reset),
        .enable_count (enable_count),
        .limit_we     (cfg_we && (cfg_addr == CFG_LIMIT)),
        .limit_wdata  (cfg_wdata[CNT_W-1:0]),
        .cont_eql     (cont_eql)
    );

    ev_state_t state;
    ev_state_t state_d;
    logic      ackout_q;
    logic      ack_rise;
    logic      code_load;
    logic      ovf_set;

    assign ack_rise = ackout && !ackout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= EV_IDLE;
            ackout_q <= 1'b0;
            ev_code  <= USC_00;
            ev_ovf   <= 1'b0;
        end else begin
            state    <= state_d;
            ackout_q <= ackout;
            if (code_load) ev_code <= uscite;
            if (ovf_set)   ev_ovf  <= 1'b1;
        end
    end

    // An edge while the consumer is stalled is dropped; the pending code stays.
    always_comb begin
        state_d   = state;
        code_load = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            EV_IDLE: begin
                if (ack_rise) begin
                    state_d   = EV_HOLD;
                    code_load = 1'b1;
                end
            end
            EV_HOLD: begin
                if (ack_rise) begin
                    if (ev_ready) code_load = 1'b1;
                    else          ovf_set   = 1'b1;
                end else if (ev_ready) begin
                    state_d = EV_IDLE;
                end
            end
            default: state_d = EV_IDLE;
        endcase
    end

    always_comb begin
        ev_valid = (state == EV_HOLD);
    end

endmodule

// File: tb/tb_b06_resp.sv
// Self-checking bench for b06_resp: directed steps followed by random
// traffic compared against a behavioural model of the responder.
module tb_b06_resp;
    import b06_pkg::*;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        cc_mux;
    logic [1:0]        uscite;
    logic              enable_count;
    logic              ackout;
    logic [DATA_W-1:0] data_in;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [DATA_W-1:0] cfg_wdata;
    logic              ev_ready;
    logic              eql;
    logic              cont_eql;
    logic              ev_valid;
    logic [1:0]        ev_code;
    logic              ev_ovf;

    always #5 clock = ~clock;

    b06_resp #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cc_mux       (cc_mux),
        .uscite       (uscite),
        .enable_count (enable_count),
        .ackout       (ackout),
        .data_in      (data_in),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .ev_ready     (ev_ready),
        .eql          (eql),
        .cont_eql     (cont_eql),
        .ev_valid     (ev_valid),
        .ev_code      (ev_code),
        .ev_ovf       (ev_ovf)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: refs indexed by select value, event buffer as a
    // capacity-one queue, counter as plain integer arithmetic.
    logic [7:0] m_ref [4];
    int         m_limit;
    int         m_count;
    bit         m_cont;
    bit         m_eql;
    bit         m_raw_prev;
    int         m_cc_prev;
    logic [1:0] ev_q [$];
    logic [1:0] m_code;
    bit         m_ovf;
    bit         m_ack_prev;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_ref[i] = 8'h00;
        m_limit    = 0;
        m_count    = 0;
        m_cont     = 0;
        m_eql      = 0;
        m_raw_prev = 0;
        m_cc_prev  = 0;
        ev_q.delete();
        m_code     = 2'b00;
        m_ovf      = 0;
        m_ack_prev = 0;
    endtask

    task automatic model_step();
        bit raw;
        bit rise;
        if (reset) begin
            model_reset();
            return;
        end
        raw = (cc_mux != 2'b00) && (data_in == m_ref[cc_mux]);
`ifdef B06_RESP_EQL_FILT_EN
        m_eql = raw && m_raw_prev && (int'(cc_mux) == m_cc_prev);
`else
        m_eql = raw;
`endif
        m_raw_prev = raw;
        m_cc_prev  = int'(cc_mux);

        m_cont = enable_count && (m_count == m_limit);
        if (cfg_we && cfg_addr == 2'd3) begin
            m_limit = int'(cfg_wdata) % (1 << CNT_W);
            m_count = 0;
        end else if (enable_count) begin
            if (m_count == m_limit) m_count = 0;
            else                    m_count = (m_count + 1) % (1 << CNT_W);
        end
        if (cfg_we && cfg_addr != 2'd3) m_ref[int'(cfg_addr) + 1] = cfg_wdata;

        rise = ackout && !m_ack_prev;
        m_ack_prev = ackout;
        if (ev_q.size() > 0 && ev_ready) void'(ev_q.pop_front());
        if (rise) begin
            if (ev_q.size() == 0) begin
                ev_q.push_back(uscite);
                m_code = uscite;
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check("eql",      {7'd0, eql},            {7'd0, m_eql});
        check("cont_eql", {7'd0, cont_eql},       {7'd0, m_cont});
        check("ev_valid", {7'd0, ev_valid},       {7'd0, ev_q.size() != 0});
        check("ev_code",  {6'd0, ev_code},        {6'd0, m_code});
        check("ev_ovf",   {7'd0, ev_ovf},         {7'd0, m_ovf});
        check("count",    {2'd0, dut.u_cnt.count}, 8'(m_count));
    endtask

    initial begin
        reset = 1'b1; cc_mux = 2'b00; uscite = 2'b00; enable_count = 1'b0;
        ackout = 1'b0; data_in = '0; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = '0; ev_ready = 1'b0;
        model_reset();
        cycle();
        cycle();
        check("rst_eql",   {7'd0, eql},      8'd0);
        check("rst_valid", {7'd0, ev_valid}, 8'd0);
        check("rst_ovf",   {7'd0, ev_ovf},   8'd0);
        reset = 1'b0;

        // compare path
        cfg_we = 1'b1; cfg_addr = CFG_REF_B; cfg_wdata = 8'h5A;
        cycle();
        cfg_we = 1'b0; cc_mux = CC_B; data_in = 8'h5A;
        cycle();
`ifdef B06_RESP_EQL_FILT_EN
        check("tp_eql_1st", {7'd0, eql}, 8'd0);
        cycle();
`endif
        check("tp_eql_hit", {7'd0, eql}, 8'd1);
        data_in = 8'h5B;
        cycle();
        check("tp_eql_miss", {7'd0, eql}, 8'd0);
        cc_mux = CC_NONE; data_in = 8'h5A;
        cycle();
        check("tp_eql_none", {7'd0, eql}, 8'd0);

        // counter wrap with limit 3
        cfg_we = 1'b1; cfg_addr = CFG_LIMIT; cfg_wdata = 8'd3;
        cycle();
        cfg_we = 1'b0; enable_count = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("tp_cnt_seq",  {2'd0, dut.u_cnt.count}, 8'((i + 1) % 4));
            check("tp_cont_seq", {7'd0, cont_eql},        8'((i % 4) == 3));
        end
        cycle();
        cycle();
        cfg_we = 1'b1; cfg_addr = CFG_LIMIT; cfg_wdata = 8'd5;
        cycle();
        check("tp_lim_clr",  {2'd0, dut.u_cnt.count}, 8'd0);
        check("tp_lim_cont", {7'd0, cont_eql},        8'd0);
        cfg_we = 1'b0; enable_count = 1'b0;

        // event handshake
        uscite = 2'b11; ev_ready = 1'b0; ackout = 1'b1;
        cycle();
        check("tp_ev_valid", {7'd0, ev_valid}, 8'd1);
        check("tp_ev_code",  {6'd0, ev_code},  8'd3);
        cycle();
        check("tp_ev_hold",  {7'd0, ev_valid}, 8'd1);
        ev_ready = 1'b1;
        cycle();
        check("tp_ev_taken", {7'd0, ev_valid}, 8'd0);
        ev_ready = 1'b0; ackout = 1'b0;
        cycle();
        ackout = 1'b1;
        cycle();
        ackout = 1'b0;
        cycle();
        uscite = 2'b01; ackout = 1'b1;
        cycle();
        check("tp_ovf_set",  {7'd0, ev_ovf},  8'd1);
        check("tp_ovf_code", {6'd0, ev_code}, 8'd3);
        ackout = 1'b0;
        cycle();
        ackout = 1'b1; ev_ready = 1'b1;
        cycle();
        check("tp_reload_code",  {6'd0, ev_code},  8'd1);
        check("tp_reload_valid", {7'd0, ev_valid}, 8'd1);
        ackout = 1'b0; ev_ready = 1'b0;

        // reset while an event is pending and the count is mid-way
        enable_count = 1'b1;
        cycle();
        cycle();
        enable_count = 1'b0;
        check("tp_pre_rst_cnt", {2'd0, dut.u_cnt.count}, 8'd2);
        reset = 1'b1;
        cycle();
        check("tp_rst_valid", {7'd0, ev_valid},        8'd0);
        check("tp_rst_code",  {6'd0, ev_code},         8'd0);
        check("tp_rst_ovf",   {7'd0, ev_ovf},          8'd0);
        check("tp_rst_cnt",   {2'd0, dut.u_cnt.count}, 8'd0);
        reset = 1'b0;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 299) == 0);
            cc_mux       = 2'($urandom_range(0, 3));
            uscite       = 2'($urandom_range(0, 3));
            enable_count = ($urandom_range(0, 3) != 0);
            ackout       = $urandom_range(0, 1) != 0;
            ev_ready     = $urandom_range(0, 2) == 0;
            data_in      = ($urandom_range(0, 2) != 0) ? m_ref[$urandom_range(1, 3)]
                                                       : 8'($urandom);
            cfg_we       = ($urandom_range(0, 15) == 0);
            cfg_addr     = 2'($urandom_range(0, 3));
            cfg_wdata    = (cfg_addr == CFG_LIMIT) ? 8'($urandom_range(0, 7))
                                                   : 8'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/b06_resp.md
# b06_resp

Datapath/responder peer of the b06 interrupt-handler FSM. It consumes the handler's `cc_mux`, `uscite`, `enable_count` and `ackout` and produces the `eql` and `cont_eql` status bits the handler branches on. It also converts each `ackout` rising edge into a valid/ready event carrying the current `uscite` code. It sits between the handler and the data/config side of the design.

## Interface
- `DATA_W`, 8: width of `data_in`, reference registers and `cfg_wdata`.
- `CNT_W`, 6: counter and limit width; must satisfy `CNT_W <= DATA_W`.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `cc_mux`  in  2  comparison select: 00 none, 01 ref_a, 10 ref_b, 11 ref_c.
- `uscite`  in  2  handler output code, captured on event.
- `enable_count`  in  1  counter increment enable.
- `ackout`  in  1  handler acknowledge; a rising edge creates an event.
- `data_in`  in  DATA_W  sampled data word.
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`  in  2  0 ref_a, 1 ref_b, 2 ref_c, 3 limit (low CNT_W bits).
- `cfg_wdata`  in  DATA_W  config write data.
- `ev_ready`  in  1  event consumer ready.
- `eql`  out  1  data match, to the handler.
- `cont_eql`  out  1  counter terminal pulse, to the handler.
- `ev_valid`  out  1  event pending.
- `ev_code`  out  2  `uscite` captured at the event.
- `ev_ovf`  out  1  sticky: an event was dropped.

## Operation
- Reset values: `eql`, `cont_eql`, `ev_valid`, `ev_ovf` = 0; `ev_code` = 00; count, refs, limit = 0; `ackout_q` = 0.
- **Config**
  - When `cfg_we=1`, the register at `cfg_addr` loads `cfg_wdata` at the clock edge.
  - A write to limit also clears count to 0. This takes priority over counting in the same cycle.
- **Compare**
  - `eql <= (cc_mux != 00) && (data_in == ref[cc_mux])`.
  - Registered; `cc_mux=00` always gives 0.
- **Counter**
  - `enable_count=0`: count holds.
  - `enable_count=1` and `count == limit`: count wraps to 0.
  - Otherwise count increments by 1, modulo 2^CNT_W.
- **Terminal pulse**
  - `cont_eql <= enable_count && (count == limit)`.
  - This is a one-cycle pulse per wrap. With limit=0, it pulses on every enabled cycle.
- **Event FSM**, states IDLE and HOLD.
  - Edge detect: `ackout_q` is `ackout` delayed one cycle; an edge is `ackout && !ackout_q`.
  - IDLE + edge → HOLD, with `ev_code <= uscite` and `ev_valid <= 1`.
  - HOLD + `ev_ready` + no edge → IDLE, with `ev_valid <= 0`.
  - HOLD + `ev_ready` + edge → stay in HOLD; `ev_code` reloads with the new `uscite`.
  - HOLD + `!ev_ready` + edge → event dropped; `ev_ovf <= 1`. `ev_ovf` clears only on reset.
- Reset mid-operation returns every state and output to its reset value on the next edge. Pending events are discarded.

## Timing
- `eql`: 1-cycle latency from `data_in`/`cc_mux`, or 2 cycles with the filter enabled.
- `cont_eql`: asserted the cycle after the wrap edge. The handler sees it on its next clock.
- `ev_valid`: rises 1 cycle after the `ackout` rising edge.
- Handshake: a transfer occurs at a clock edge with `ev_valid && ev_ready`. `ev_code` is stable while `ev_valid=1 && !ev_ready`.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `B06_RESP_EQL_FILT_EN` defined:
  - `eql` asserts only after 2 consecutive cycles of raw match with unchanged `cc_mux`.
  - It deasserts on the first non-match cycle.
- Macro undefined: `eql` is the raw 1-cycle registered match.

## Structure
- `b06_pkg` holds:
  - `cc_mux` encodings (`CC_NONE`, `CC_A`, `CC_B`, `CC_C`);
  - `uscite` codes;
  - cfg address constants (`CFG_REF_A`..`CFG_LIMIT`);
  - event FSM state typedef (`EV_IDLE`, `EV_HOLD`).
- Sub-module `b06_resp_cnt` contains the counter, limit register and terminal pulse. The top level holds the refs, compare, filter and event FSM.

## Test plan
- Reset, then write ref_b=0x5A, drive `cc_mux=10`, `data_in=0x5A` → `eql=1` next cycle (2nd cycle with the filter). `data_in=0x5B` → `eql=0`. `cc_mux=00` → `eql=0`.
- limit=3, `enable_count` held at 1 → count sequence 0,1,2,3,0. `cont_eql` pulses once per 4 cycles, the cycle after count=3.
- Write limit=5 while `enable_count=1` with count=2 → count becomes 0; no `cont_eql` pulse.
- `ackout` 0→1 with `uscite=11`, `ev_ready=0` → `ev_valid=1`, `ev_code=11`, held. Then `ev_ready=1` → `ev_valid=0` next cycle.
- In HOLD with `ev_ready=0`, second `ackout` edge with `uscite=01` → `ev_ovf=1`, `ev_code` stays 11. Repeat with `ev_ready=1` → `ev_code=01`, `ev_valid` stays 1.
- Assert `reset` mid-HOLD with count=2 → next cycle all outputs 0 and count=0.
